// File: rtl/ecpa_arbiter.sv
// Round-robin arbiter/sequencer sharing one ECPA point-adder core between NUM_REQ requesters.
// Latches the winner's operands, drives the core handshake, returns results and aborts hung operations.
module ecpa_arbiter #(
  parameter int unsigned WIDTH   = 256,
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ*WIDTH-1:0]   i_p,
  input  logic [NUM_REQ*WIDTH-1:0]   i_x1,
  input  logic [NUM_REQ*WIDTH-1:0]   i_y1,
  input  logic [NUM_REQ*WIDTH-1:0]   i_z1,
  input  logic [NUM_REQ*WIDTH-1:0]   i_x2,
  input  logic [NUM_REQ*WIDTH-1:0]   i_y2,
  input  logic [NUM_REQ*WIDTH-1:0]   i_z2,
  output logic [NUM_REQ-1:0]         o_gnt,
  output logic [NUM_REQ-1:0]         o_done,
  output logic [NUM_REQ-1:0]         o_err,
  output logic [WIDTH-1:0]           o_x3,
  output logic [WIDTH-1:0]           o_y3,
  output logic [WIDTH-1:0]           o_z3,
  output logic                       o_busy,
  output logic                       o_ecpa_rst_n,
  output logic                       o_ecpa_start,
  output logic [WIDTH-1:0]           o_ecpa_p,
  output logic [WIDTH-1:0]           o_ecpa_x1,
  output logic [WIDTH-1:0]           o_ecpa_y1,
  output logic [WIDTH-1:0]           o_ecpa_z1,
  output logic [WIDTH-1:0]           o_ecpa_x2,
  output logic [WIDTH-1:0]           o_ecpa_y2,
  output logic [WIDTH-1:0]           o_ecpa_z2,
  input  logic [WIDTH-1:0]           i_ecpa_x3,
  input  logic [WIDTH-1:0]           i_ecpa_y3,
  input  logic [WIDTH-1:0]           i_ecpa_z3,
  input  logic                       i_ecpa_done
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE,
    ST_CLEAR
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   cand;
  logic [CNT_W-1:0]   cnt;
  logic               finish_c;
  logic               timeout_c;
  logic [WIDTH-1:0]   sel_p;
  logic [WIDTH-1:0]   sel_x1;
  logic [WIDTH-1:0]   sel_y1;
  logic [WIDTH-1:0]   sel_z1;
  logic [WIDTH-1:0]   sel_x2;
  logic [WIDTH-1:0]   sel_y2;
  logic [WIDTH-1:0]   sel_z2;

  // Round-robin pick: scan downward so the requester closest above ptr wins last.
  always_comb begin
    pick = ptr;
    cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((32'(ptr) + 32'(i)) % NUM_REQ);
      if (i_req[cand]) pick = cand;
    end
  end

  // Operand mux for the current pick.
  always_comb begin
    sel_p  = '0;
    sel_x1 = '0;
    sel_y1 = '0;
    sel_z1 = '0;
    sel_x2 = '0;
    sel_y2 = '0;
    sel_z2 = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (pick == IDX_W'(r)) begin
        sel_p  = i_p[r*WIDTH +: WIDTH];
        sel_x1 = i_x1[r*WIDTH +: WIDTH];
        sel_y1 = i_y1[r*WIDTH +: WIDTH];
        sel_z1 = i_z1[r*WIDTH +: WIDTH];
        sel_x2 = i_x2[r*WIDTH +: WIDTH];
        sel_y2 = i_y2[r*WIDTH +: WIDTH];
        sel_z2 = i_z2[r*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Core completion wins over the watchdog in the final RUN cycle.
  always_comb begin
    next_state = state;
    timeout_c  = 1'b0;
    finish_c   = 1'b0;
    unique case (state)
      ST_IDLE:  if (|i_req) next_state = ST_LOAD;
      ST_LOAD:  next_state = ST_RUN;
      ST_RUN: begin
        timeout_c = !i_ecpa_done && (cnt == CNT_W'(TIMEOUT - 1));
        finish_c  = i_ecpa_done || timeout_c;
        if (finish_c) next_state = ST_DONE;
      end
      ST_DONE:  next_state = ST_CLEAR;
      ST_CLEAR: next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr          <= '0;
      win          <= '0;
      cnt          <= '0;
      o_gnt        <= '0;
      o_done       <= '0;
      o_err        <= '0;
      o_busy       <= 1'b0;
      o_ecpa_start <= 1'b0;
      o_x3         <= '0;
      o_y3         <= '0;
      o_z3         <= '0;
      o_ecpa_p     <= '0;
      o_ecpa_x1    <= '0;
      o_ecpa_y1    <= '0;
      o_ecpa_z1    <= '0;
      o_ecpa_x2    <= '0;
      o_ecpa_y2    <= '0;
      o_ecpa_z2    <= '0;
    end else begin
      o_done       <= '0;
      o_err        <= '0;
      o_busy       <= (next_state != ST_IDLE);
      o_ecpa_start <= (next_state == ST_RUN);
      case (state)
        ST_IDLE: begin
          if (|i_req) begin
            win       <= pick;
            o_gnt     <= NUM_REQ'(1) << pick;
            o_ecpa_p  <= sel_p;
            o_ecpa_x1 <= sel_x1;
            o_ecpa_y1 <= sel_y1;
            o_ecpa_z1 <= sel_z1;
            o_ecpa_x2 <= sel_x2;
            o_ecpa_y2 <= sel_y2;
            o_ecpa_z2 <= sel_z2;
          end
        end
        ST_LOAD: cnt <= '0;
        ST_RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (i_ecpa_done) begin
            o_x3 <= i_ecpa_x3;
            o_y3 <= i_ecpa_y3;
            o_z3 <= i_ecpa_z3;
          end
          if (finish_c) o_done <= o_gnt;
          if (timeout_c) o_err <= o_gnt;
        end
        ST_DONE: begin
          ptr   <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
          o_gnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_ecpa_rst_n = i_rst_n && (state != ST_CLEAR);

endmodule

// File: tb/tb_ecpa_arbiter.sv
// Self-checking bench for ecpa_arbiter: behavioural core (projective add mod p) and
// round-robin reference model, directed scenarios plus randomized operations.
module tb_ecpa_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 2;
  localparam int unsigned TO = 16;

  logic             clk = 1'b0;
  logic             i_rst_n;
  logic [N-1:0]     i_req;
  logic [N*W-1:0]   i_p, i_x1, i_y1, i_z1, i_x2, i_y2, i_z2;
  logic [N-1:0]     o_gnt, o_done, o_err;
  logic [W-1:0]     o_x3, o_y3, o_z3;
  logic             o_busy, o_ecpa_rst_n, o_ecpa_start;
  logic [W-1:0]     o_ecpa_p, o_ecpa_x1, o_ecpa_y1, o_ecpa_z1, o_ecpa_x2, o_ecpa_y2, o_ecpa_z2;
  logic [W-1:0]     i_ecpa_x3, i_ecpa_y3, i_ecpa_z3;
  logic             i_ecpa_done;

  int               n_cmp = 0;
  int               n_bad = 0;
  int               model_ptr = 0;
  logic [W-1:0]     opv [N][7];
  logic [W-1:0]     exp_x3, exp_y3, exp_z3;
  longint           primes [5] = '{23, 29, 31, 97, 65521};

  always #5 clk = ~clk;

  ecpa_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_req(i_req),
    .i_p(i_p), .i_x1(i_x1), .i_y1(i_y1), .i_z1(i_z1),
    .i_x2(i_x2), .i_y2(i_y2), .i_z2(i_z2),
    .o_gnt(o_gnt), .o_done(o_done), .o_err(o_err),
    .o_x3(o_x3), .o_y3(o_y3), .o_z3(o_z3),
    .o_busy(o_busy), .o_ecpa_rst_n(o_ecpa_rst_n), .o_ecpa_start(o_ecpa_start),
    .o_ecpa_p(o_ecpa_p), .o_ecpa_x1(o_ecpa_x1), .o_ecpa_y1(o_ecpa_y1), .o_ecpa_z1(o_ecpa_z1),
    .o_ecpa_x2(o_ecpa_x2), .o_ecpa_y2(o_ecpa_y2), .o_ecpa_z2(o_ecpa_z2),
    .i_ecpa_x3(i_ecpa_x3), .i_ecpa_y3(i_ecpa_y3), .i_ecpa_z3(i_ecpa_z3),
    .i_ecpa_done(i_ecpa_done)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic longint md(input longint a, input longint p);
    return ((a % p) + p) % p;
  endfunction

  // Projective point addition (no doubling case), all arithmetic mod p.
  function automatic void ec_add(input longint p, x1, y1, z1, x2, y2, z2,
                                 output longint x3, y3, z3);
    longint u, v, uu, vv, vvv, r, a;
    u   = md(y2 * z1 - y1 * z2, p);
    v   = md(x2 * z1 - x1 * z2, p);
    uu  = md(u * u, p);
    vv  = md(v * v, p);
    vvv = md(v * vv, p);
    r   = md(md(vv * x1, p) * z2, p);
    a   = md(md(md(uu * z1, p) * z2, p) - vvv - 2 * r, p);
    x3  = md(v * a, p);
    y3  = md(u * md(r - a, p) - md(md(vvv * y1, p) * z2, p), p);
    z3  = md(md(vvv * z1, p) * z2, p);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_core();
    i_ecpa_x3 = $urandom;
    i_ecpa_y3 = $urandom;
    i_ecpa_z3 = $urandom;
  endtask

  task automatic set_ops(input int r, input longint p, x1, y1, z1, x2, y2, z2);
    opv[r][0] = W'(p);  opv[r][1] = W'(x1); opv[r][2] = W'(y1); opv[r][3] = W'(z1);
    opv[r][4] = W'(x2); opv[r][5] = W'(y2); opv[r][6] = W'(z2);
    i_p[r*W +: W]  = W'(p);
    i_x1[r*W +: W] = W'(x1); i_y1[r*W +: W] = W'(y1); i_z1[r*W +: W] = W'(z1);
    i_x2[r*W +: W] = W'(x2); i_y2[r*W +: W] = W'(y2); i_z2[r*W +: W] = W'(z2);
  endtask

  task automatic rand_ops(input int r);
    longint p;
    p = primes[$urandom_range(0, 4)];
    set_ops(r, p,
            longint'($urandom_range(0, 32'(p - 1))), longint'($urandom_range(0, 32'(p - 1))),
            longint'($urandom_range(1, 32'(p - 1))), longint'($urandom_range(0, 32'(p - 1))),
            longint'($urandom_range(0, 32'(p - 1))), longint'($urandom_range(1, 32'(p - 1))));
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    model_ptr = 0;
    exp_x3 = '0; exp_y3 = '0; exp_z3 = '0;
  endtask

  // One full operation starting from an IDLE cycle with i_req already driven.
  // wiggle: 0 keep i_req, 1 randomize it during RUN, 2 drop it during RUN.
  task automatic do_op(input int lat, input bit hang, input int wiggle);
    int            w;
    int            runs;
    longint        rx, ry, rz;
    logic [N-1:0]  exp_g;
    logic [N-1:0]  exp_e;
    w = -1;
    for (int k = 0; k < int'(N); k++) begin
      int c;
      c = (model_ptr + k) % int'(N);
      if (w < 0 && i_req[c]) w = c;
    end
    if (w < 0) w = 0;
    exp_g = N'(1) << w;
    exp_e = hang ? exp_g : '0;
    rx = 0; ry = 0; rz = 0;

    tick();
    n_cmp++;
    if (o_gnt !== exp_g || o_busy !== 1'b1 || o_ecpa_start !== 1'b0 || o_done !== '0)
      begin n_bad++; $display("FAIL load_state: gnt=%b busy=%b start=%b done=%b, expected gnt=%b busy=1 start=0 done=0",
                              o_gnt, o_busy, o_ecpa_start, o_done, exp_g); end
    n_cmp++;
    if ({o_ecpa_p, o_ecpa_x1, o_ecpa_y1, o_ecpa_z1, o_ecpa_x2, o_ecpa_y2, o_ecpa_z2} !==
        {opv[w][0], opv[w][1], opv[w][2], opv[w][3], opv[w][4], opv[w][5], opv[w][6]})
      begin n_bad++; $display("FAIL load_operands: p=%0d x1=%0d z2=%0d, expected p=%0d x1=%0d z2=%0d (req %0d)",
                              o_ecpa_p, o_ecpa_x1, o_ecpa_z2, opv[w][0], opv[w][1], opv[w][6], w); end

    runs = 0;
    tick();
    while (o_ecpa_start === 1'b1 && runs <= int'(TO) + 4) begin
      runs++;
      n_cmp++;
      if (o_gnt !== exp_g || o_done !== '0 || o_ecpa_rst_n !== 1'b1)
        begin n_bad++; $display("FAIL run_state: cycle %0d gnt=%b done=%b ecpa_rst_n=%b, expected gnt=%b done=0 ecpa_rst_n=1",
                                runs, o_gnt, o_done, o_ecpa_rst_n, exp_g); end
      if (wiggle == 1) i_req = N'($urandom);
      else if (wiggle == 2) i_req = '0;
      if (!hang && runs == lat) begin
        ec_add(longint'(opv[w][0]), longint'(opv[w][1]), longint'(opv[w][2]), longint'(opv[w][3]),
               longint'(opv[w][4]), longint'(opv[w][5]), longint'(opv[w][6]), rx, ry, rz);
        i_ecpa_x3 = W'(rx); i_ecpa_y3 = W'(ry); i_ecpa_z3 = W'(rz);
        i_ecpa_done = 1'b1;
      end else begin
        i_ecpa_done = 1'b0;
        junk_core();
      end
      tick();
    end
    i_ecpa_done = 1'b0;
    junk_core();
    if (!hang) begin
      exp_x3 = W'(rx); exp_y3 = W'(ry); exp_z3 = W'(rz);
    end

    n_cmp++;
    if (runs != (hang ? int'(TO) : lat))
      begin n_bad++; $display("FAIL run_length: got %0d cycles, expected %0d", runs, hang ? int'(TO) : lat); end
    n_cmp++;
    if (o_done !== exp_g || o_err !== exp_e)
      begin n_bad++; $display("FAIL done_pulse: done=%b err=%b, expected done=%b err=%b", o_done, o_err, exp_g, exp_e); end
    n_cmp++;
    if (o_x3 !== exp_x3 || o_y3 !== exp_y3 || o_z3 !== exp_z3)
      begin n_bad++; $display("FAIL result: got (%0d,%0d,%0d), expected (%0d,%0d,%0d)",
                              o_x3, o_y3, o_z3, exp_x3, exp_y3, exp_z3); end
    n_cmp++;
    if (o_ecpa_start !== 1'b0 || o_gnt !== exp_g || o_busy !== 1'b1)
      begin n_bad++; $display("FAIL done_state: start=%b gnt=%b busy=%b, expected start=0 gnt=%b busy=1",
                              o_ecpa_start, o_gnt, o_busy, exp_g); end
    model_ptr = (w + 1) % int'(N);

    tick();
    n_cmp++;
    if (o_ecpa_rst_n !== 1'b0 || o_gnt !== '0 || o_done !== '0 || o_err !== '0 || o_busy !== 1'b1)
      begin n_bad++; $display("FAIL clear_state: ecpa_rst_n=%b gnt=%b done=%b err=%b busy=%b, expected 0 0 0 0 1",
                              o_ecpa_rst_n, o_gnt, o_done, o_err, o_busy); end

    tick();
    n_cmp++;
    if (o_ecpa_rst_n !== 1'b1 || o_busy !== 1'b0 || o_gnt !== '0 || o_done !== '0 ||
        o_x3 !== exp_x3 || o_y3 !== exp_y3 || o_z3 !== exp_z3)
      begin n_bad++; $display("FAIL idle_state: ecpa_rst_n=%b busy=%b gnt=%b done=%b x3=%0d, expected 1 0 0 0 x3=%0d",
                              o_ecpa_rst_n, o_busy, o_gnt, o_done, o_x3, exp_x3); end
  endtask

  task automatic check_all_zero(input string name);
    n_cmp++;
    if (o_gnt !== '0 || o_done !== '0 || o_err !== '0 || o_busy !== 1'b0 || o_ecpa_start !== 1'b0 ||
        o_ecpa_rst_n !== 1'b0 || {o_x3, o_y3, o_z3} !== '0 ||
        {o_ecpa_p, o_ecpa_x1, o_ecpa_y1, o_ecpa_z1, o_ecpa_x2, o_ecpa_y2, o_ecpa_z2} !== '0)
      begin n_bad++; $display("FAIL %s: gnt=%b done=%b err=%b busy=%b start=%b ecpa_rst_n=%b x3=%0d p=%0d, expected all 0",
                              name, o_gnt, o_done, o_err, o_busy, o_ecpa_start, o_ecpa_rst_n, o_x3, o_ecpa_p); end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    tick();
    tick();
    check_all_zero("reset_outputs");
    i_rst_n = 1'b1;
    #1;
    n_cmp++;
    if (o_ecpa_rst_n !== 1'b1)
      begin n_bad++; $display("FAIL reset_release: ecpa_rst_n=%b, expected 1", o_ecpa_rst_n); end
    model_ptr = 0;
    exp_x3 = '0; exp_y3 = '0; exp_z3 = '0;
  endtask

  task automatic test_single();
    set_ops(0, 23, 5, 17, 1, 7, 13, 1);
    i_req = 2'b01;
    do_op(3, 1'b0, 0);
    i_req = '0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    rand_ops(0);
    rand_ops(1);
    i_req = 2'b11;
    for (int k = 0; k < 4; k++) do_op($urandom_range(1, 5), 1'b0, 0);
    i_req = '0;
  endtask

  task automatic test_withdraw();
    rand_ops(1);
    i_req = 2'b10;
    do_op(4, 1'b0, 2);
    i_req = '0;
  endtask

  task automatic test_timeout();
    rand_ops(0);
    i_req = 2'b01;
    do_op(1, 1'b1, 0);
    rand_ops(1);
    i_req = 2'b10;
    do_op(2, 1'b0, 0);
    i_req = '0;
  endtask

  task automatic test_reset_mid_run();
    rand_ops(0);
    i_req = 2'b01;
    do_op(2, 1'b0, 0);
    rand_ops(1);
    i_req = 2'b10;
    tick();
    tick();
    tick();
    i_ecpa_done = 1'b0;
    i_rst_n = 1'b0;
    tick();
    check_all_zero("reset_mid_run");
    i_rst_n = 1'b1;
    model_ptr = 0;
    exp_x3 = '0; exp_y3 = '0; exp_z3 = '0;
    i_req = 2'b11;
    do_op(3, 1'b0, 0);
    i_req = '0;
  endtask

  task automatic test_stray_done();
    i_req = '0;
    junk_core();
    i_ecpa_done = 1'b1;
    tick();
    i_ecpa_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (o_busy !== 1'b0 || o_gnt !== '0 || o_done !== '0 || o_err !== '0 ||
          o_x3 !== exp_x3 || o_y3 !== exp_y3 || o_z3 !== exp_z3)
        begin n_bad++; $display("FAIL stray_done: busy=%b gnt=%b done=%b x3=%0d, expected 0 0 0 x3=%0d",
                                o_busy, o_gnt, o_done, o_x3, exp_x3); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      int gap;
      gap = $urandom_range(0, 2);
      i_req = '0;
      for (int g = 0; g < gap; g++) begin
        tick();
        n_cmp++;
        if (o_busy !== 1'b0 || o_gnt !== '0)
          begin n_bad++; $display("FAIL random_idle: busy=%b gnt=%b, expected 0 0", o_busy, o_gnt); end
      end
      rand_ops(0);
      rand_ops(1);
      i_req = N'($urandom_range(1, 3));
      do_op(($urandom_range(0, 3) == 0) ? int'(TO) : int'($urandom_range(1, 6)),
            $urandom_range(0, 6) == 0, int'($urandom_range(0, 2)));
    end
    i_req = '0;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_req = '0;
    i_p = '0; i_x1 = '0; i_y1 = '0; i_z1 = '0; i_x2 = '0; i_y2 = '0; i_z2 = '0;
    i_ecpa_done = 1'b0;
    junk_core();
    for (int r = 0; r < int'(N); r++) for (int k = 0; k < 7; k++) opv[r][k] = '0;
    exp_x3 = '0; exp_y3 = '0; exp_z3 = '0;

    test_reset();
    test_single();
    test_back_to_back();
    test_withdraw();
    test_timeout();
    test_reset_mid_run();
    test_stray_done();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ecpa_arbiter.md
# ecpa_arbiter

Round-robin arbiter and sequencer that shares one `ECPA` projective point-adder core between `NUM_REQ` requesters, such as scalar-multiply engines or a host port. It latches the winning requester's operands and drives the `ECPA` start/done handshake. It clears the core with a one-cycle reset between operations and returns `X3/Y3/Z3` to the winner with a one-cycle done pulse. A watchdog aborts any operation that the core does not complete.

## Interface
- `WIDTH`, 256, field/coordinate width in bits.
- `NUM_REQ`, 2, number of requesters (legal 2..8).
- `TIMEOUT`, 4096, maximum cycles in RUN before abort (≥ 2).
- `i_clk`  in  1  single clock, all logic rising-edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_req`  in  NUM_REQ  per-requester request level.
- `i_p, i_x1, i_y1, i_z1, i_x2, i_y2, i_z2`  in  NUM_REQ*WIDTH each  flattened operands, requester r at bits [r*WIDTH +: WIDTH].
- `o_gnt`  out  NUM_REQ  one-hot owner of the core, 0 when idle.
- `o_done`  out  NUM_REQ  one-cycle completion pulse to owner.
- `o_err`  out  NUM_REQ  one-cycle timeout pulse, coincident with `o_done`.
- `o_x3, o_y3, o_z3`  out  WIDTH each  result of last operation, valid when any `o_done` bit is high.
- `o_busy`  out  1  high in every state except IDLE.
- `o_ecpa_rst_n`  out  1  reset to core.
- `o_ecpa_start`  out  1  start to core.
- `o_ecpa_p, o_ecpa_x1 … o_ecpa_z2`  out  WIDTH each  latched operands to core.
- `i_ecpa_x3, i_ecpa_y3, i_ecpa_z3`  in  WIDTH each  core results.
- `i_ecpa_done`  in  1  core completion level.

## Operation
- **States:** IDLE, LOAD, RUN, DONE, CLEAR.
- **IDLE:** if `i_req != 0`, pick the winner. Search starts at pointer `ptr` and moves upward, wrapping modulo NUM_REQ. Go to LOAD.
- **LOAD:**
  - Copy the winner's seven operands into the `o_ecpa_*` registers.
  - Set `o_gnt` one-hot.
  - Clear the watchdog counter.
  - Go to RUN.
- **RUN:**
  - `o_ecpa_start` = 1 and the counter increments each cycle.
  - If `i_ecpa_done` is sampled high, capture `i_ecpa_x3/y3/z3` into `o_x3/o_y3/o_z3` and go to DONE.
  - Otherwise, when the counter reaches TIMEOUT−1, go to DONE with an error flag set. Results are left unchanged in this case.
- **DONE:**
  - `o_ecpa_start` = 0.
  - `o_done[winner]` = 1, and `o_err[winner]` = 1 if the error flag is set.
  - Set `ptr` to winner+1 mod NUM_REQ.
  - Go to CLEAR.
- **CLEAR:** `o_ecpa_rst_n` = 0 for exactly this cycle. `o_gnt` clears. Go to IDLE.
- `o_ecpa_rst_n` = `i_rst_n` AND (state ≠ CLEAR), combinational.
- Operand registers hold their values from LOAD until the next LOAD.
- `i_req` is only sampled in IDLE. Operations are never aborted by the requester: dropping `i_req` after grant has no effect, and the result is still delivered.
- A requester that keeps `i_req` high after its `o_done` is re-granted only when it wins round-robin again. Two continuous requesters therefore alternate.
- `i_ecpa_done` outside RUN is ignored.

## Timing
- **Reset (any state, mid-operation included):**
  - Next state is IDLE and `ptr` = 0.
  - `o_gnt`, `o_done`, `o_err`, `o_busy`, `o_ecpa_start` = 0.
  - `o_x3/o_y3/o_z3` and all `o_ecpa_*` operands = 0.
  - `o_ecpa_rst_n` = 0 while `i_rst_n` = 0.
- **Sequence from request to next arbitration:**
  - Request seen in IDLE at edge 0.
  - LOAD during cycle 1.
  - `o_ecpa_start` high from cycle 2.
  - `i_ecpa_done` first high in cycle n gives DONE and `o_done` in cycle n+1, then CLEAR in n+2, then IDLE in n+3.
  - Fixed overhead is 4 cycles per operation.
- **Result timing:** results are registered, stable from DONE until the next DONE.
- **Timeout:** RUN lasts exactly TIMEOUT cycles, then DONE with `o_err`.

## Test plan
- **Single request, small field.** Requester 0 sends p=23, P1=(5,17,1), P2=(7,13,1) with a behavioural core model. Expected:
  - `o_gnt`=01 one cycle after the request.
  - `o_ecpa_start` high until done.
  - `o_done`=01 for one cycle, with `o_x3/y3/z3` equal to the model's sum.
  - `o_ecpa_rst_n` low exactly one cycle.
- **Simultaneous requests after reset.** Both requesters hold `i_req` constantly. Expected grant order 0,1,0,1. No `o_done` ever has two bits set.
- **Requester withdraws mid-operation.** Requester 1 drops `i_req` during RUN. Expected: operation completes and `o_done`=10 with results.
- **Watchdog timeout.** TIMEOUT=16 and the core never asserts done. Expected:
  - RUN lasts 16 cycles.
  - `o_done` and `o_err` pulse together for the owner.
  - Results keep their previous value.
  - Next request is served normally.
- **Reset mid-RUN.** Pull `i_rst_n` low for one cycle while in RUN. Expected:
  - All outputs 0.
  - No `o_done` pulse.
  - `ptr`=0, so a subsequent request from requester 1 with requester 0 also requesting grants 0 first.
- **Stray core done.** Pulse `i_ecpa_done` while IDLE. Expected: no state change and no `o_done`.
